// File: rtl/gpu_mem_responder.sv
// Avalon-MM byte RAM responder for the GPU controller's m1 port: pipelined reads with fixed latency,
// read throttling via s1_waitrequest, and sticky range/protocol error flags. Optional stall injection: MEM_RESP_STALL_EN.
module gpu_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0800_0000,
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 2,
    parameter int          STALL_PERIOD = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] s1_address,
    input  logic [7:0]  s1_writedata,
    input  logic        s1_write,
    input  logic        s1_read,
    output logic        s1_waitrequest,
    output logic [7:0]  s1_readdata,
    output logic        s1_readdatavalid,
    output logic        range_err,
    output logic        protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_PENDING + 1);

    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("READ_LATENCY must be at least 1");
    end
    if (MAX_PENDING < 1 || MAX_PENDING > READ_LATENCY) begin : g_bad_pending
        $error("MAX_PENDING must be in 1..READ_LATENCY");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two");
    end
    if (STALL_PERIOD < 2) begin : g_bad_stall_period
        $error("STALL_PERIOD must be at least 2");
    end

    logic [31:0]          offset;
    logic                 hit;
    logic [AW-1:0]        idx;
    logic [7:0]           rd_sample;
    logic                 stall;
    logic                 read_acc;
    logic                 write_acc;
    logic [CW-1:0]        pending;
    logic [7:0]           mem [DEPTH];
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [7:0]           dat_pipe [READ_LATENCY];

    // Unsigned subtraction wraps for addresses below the base, so the explicit >= guard is required.
    assign offset = s1_address - BASE_ADDR;
    assign hit    = (s1_address >= BASE_ADDR) && (offset < 32'(DEPTH));
    assign idx    = offset[AW-1:0];

`ifdef MEM_RESP_STALL_EN
    localparam int SW = $clog2(STALL_PERIOD);
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    assign stall = (stall_cnt == SW'(STALL_PERIOD - 1));
`else
    assign stall = 1'b0;
`endif

    // A return firing this cycle frees a slot, so a read at the limit can still be accepted.
    assign s1_waitrequest = !reset_n || stall ||
                            (s1_read && (pending == CW'(MAX_PENDING)) && !s1_readdatavalid);

    assign write_acc = s1_write && !s1_waitrequest;
    assign read_acc  = s1_read && !s1_write && !s1_waitrequest;
    assign rd_sample = hit ? mem[idx] : 8'h00;

    always_ff @(posedge clock) begin
        if (write_acc && hit) begin
            mem[idx] <= s1_writedata;
        end
    end

    // Data stages only load behind a valid bit, so the last stage holds the most recent return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_pipe[k] <= 8'h00;
            end
        end else begin
            vld_pipe[0] <= read_acc;
            if (read_acc) begin
                dat_pipe[0] <= rd_sample;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) begin
                    dat_pipe[k] <= dat_pipe[k-1];
                end
            end
        end
    end

    assign s1_readdatavalid = vld_pipe[READ_LATENCY-1];
    assign s1_readdata      = dat_pipe[READ_LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            case ({read_acc, s1_readdatavalid})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            range_err    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if ((read_acc || write_acc) && !hit) begin
                range_err <= 1'b1;
            end
            if (s1_read && s1_write && !s1_waitrequest) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Bench for gpu_mem_responder: a queue-based reference model checked every cycle, plus hand-computed
// literal expectations on returned bytes, latency and flags.
module tb_gpu_mem_responder;
    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam int          MAXP  = 2;
`ifdef MEM_RESP_STALL_EN
    localparam int          SPER  = 8;
`endif

    logic        clock;
    logic        reset_n;
    logic [31:0] s1_address;
    logic [7:0]  s1_writedata;
    logic        s1_write;
    logic        s1_read;
    logic        s1_waitrequest;
    logic [7:0]  s1_readdata;
    logic        s1_readdatavalid;
    logic        range_err;
    logic        protocol_err;

    gpu_mem_responder dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .s1_address       (s1_address),
        .s1_writedata     (s1_writedata),
        .s1_write         (s1_write),
        .s1_read          (s1_read),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .range_err        (range_err),
        .protocol_err     (protocol_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         r;
        logic [7:0] d;
    } ret_t;

    ret_t       rq[$];
    logic [7:0] mem_m [int];
    logic [7:0] m_rdata;
    logic       m_range;
    logic       m_proto;
    int         since_rel;
    logic [7:0] got_q[$];
    time        got_t[$];

    always @(negedge clock) begin
        logic     fire;
        logic     m_wait;
        logic     stall;
        logic     hit;
        longint   a;
        longint   off;
        if (!reset_n) begin
            rq.delete();
            m_rdata   = 8'h00;
            m_range   = 1'b0;
            m_proto   = 1'b0;
            since_rel = 0;
            chk("rst_waitrequest", s1_waitrequest, 1'b1);
            chk("rst_readdatavalid", s1_readdatavalid, 1'b0);
            chk("rst_readdata", s1_readdata, 8'h00);
            chk("rst_range_err", range_err, 1'b0);
            chk("rst_protocol_err", protocol_err, 1'b0);
        end else begin
            foreach (rq[i]) rq[i].r--;
            fire = (rq.size() > 0) && (rq[0].r == 0);
            if (fire) m_rdata = rq[0].d;
`ifdef MEM_RESP_STALL_EN
            stall = ((since_rel % SPER) == SPER - 1);
`else
            stall = 1'b0;
`endif
            m_wait = stall || (s1_read && (rq.size() == MAXP) && !fire);
            chk("waitrequest", s1_waitrequest, m_wait);
            chk("readdatavalid", s1_readdatavalid, fire);
            chk("readdata", s1_readdata, m_rdata);
            chk("range_err", range_err, m_range);
            chk("protocol_err", protocol_err, m_proto);
            if (s1_readdatavalid) begin
                got_q.push_back(s1_readdata);
                got_t.push_back($time);
            end
            if (fire) void'(rq.pop_front());
            if (!m_wait && (s1_read || s1_write)) begin
                a   = longint'(s1_address);
                off = a - longint'(BASE);
                hit = (off >= 0) && (off < DEPTH);
                if (!hit) m_range = 1'b1;
                if (s1_write) begin
                    if (s1_read) m_proto = 1'b1;
                    if (hit) mem_m[int'(off)] = s1_writedata;
                end else begin
                    rq.push_back('{r: LAT, d: (hit ? mem_m[int'(off)] : 8'h00)});
                end
            end
            since_rel++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [7:0] d, output time t_req);
        logic w;
        bit   done;
        done = 0;
        t_req = 0;
        s1_read = rd;
        s1_write = wr;
        s1_address = a;
        s1_writedata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            w = s1_waitrequest;
            t_req = $time;
            @(posedge clock);
            #1;
            if (!w) done = 1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: request addr %0h not accepted within 40 cycles", a);
        end
    endtask

    task automatic idle(input int n);
        s1_read = 1'b0;
        s1_write = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
        time t;
        issue(1'b0, 1'b1, a, d, t);
    endtask

    task automatic rd_byte(input logic [31:0] a, output time t);
        issue(1'b1, 1'b0, a, 8'h00, t);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] exp_q[$];

    initial begin
        time t0;
        time t_dummy;
        int  saved;
        reset_n = 1'b0;
        s1_read = 1'b0;
        s1_write = 1'b0;
        s1_address = '0;
        s1_writedata = '0;
        exp_q = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h11, 8'h33, 8'h77, 8'h5A};

        @(negedge clock);
        chk("lit_rst_wait", s1_waitrequest, 1'b1);
        chk("lit_rst_valid", s1_readdatavalid, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Write then read back with latency pinned.
        wr_byte(BASE + 32'h10, 8'hA5);
        rd_byte(BASE + 32'h10, t0);
        idle(4);
        if (got_t.size() > 0) chk("lit_latency_cycles", 32'((got_t[0] - t0) / 10), 32'd2);
        else chk("lit_latency_no_return", 32'(got_t.size()), 32'd1);

        // Streamed reads behind the pending limit.
        for (int i = 0; i < 4; i++) wr_byte(BASE + 32'(i), 8'h11 + 8'(i));
        for (int i = 0; i < 4; i++) rd_byte(BASE + 32'(i), t_dummy);
        idle(5);

        // First byte past the window, then a dropped write there.
        rd_byte(BASE + 32'h1000, t_dummy);
        idle(3);
        chk("lit_range_err_set", range_err, 1'b1);
        wr_byte(BASE + 32'h1000, 8'h99);
        rd_byte(BASE, t_dummy);
        idle(4);
        chk("lit_range_err_sticky", range_err, 1'b1);
        chk("lit_protocol_err_clear", protocol_err, 1'b0);

        // Read followed by a write to the same byte.
        wr_byte(BASE + 32'h20, 8'h33);
        rd_byte(BASE + 32'h20, t_dummy);
        wr_byte(BASE + 32'h20, 8'h77);
        rd_byte(BASE + 32'h20, t_dummy);
        idle(4);

        // Read and write together: write wins, read dropped.
        saved = got_q.size();
        issue(1'b1, 1'b1, BASE + 32'h5, 8'h5A, t_dummy);
        idle(4);
        chk("lit_collision_no_return", 32'(got_q.size()), 32'(saved));
        chk("lit_protocol_err_set", protocol_err, 1'b1);
        rd_byte(BASE + 32'h5, t_dummy);
        idle(4);

        // Two reads in flight, then a one-cycle reset pulse.
        saved = got_q.size();
        rd_byte(BASE + 32'h10, t_dummy);
        rd_byte(BASE, t_dummy);
        s1_read = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("lit_pulse_wait", s1_waitrequest, 1'b1);
        chk("lit_pulse_range_err", range_err, 1'b0);
        chk("lit_pulse_protocol_err", protocol_err, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
`ifdef MEM_RESP_STALL_EN
            if (i == 7 || i == 15 || i == 23) chk("lit_stall_cycle", s1_waitrequest, 1'b1);
`endif
        end
        chk("lit_pulse_no_return", 32'(got_q.size()), 32'(saved));

        // Every returned byte against the hand-computed list.
        chk("lit_return_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("lit_return_%0d", i), got_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
